// File: rtl/alu_operand_sequencer.sv
// Step-button driven operand entry for the 4-bit ALU: debounce, X/Y/F capture, result hold.
// Optional ALU_SEQ_LIVE_FSEL_EN: in SHOW, f and result follow the function switches live.
module alu_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [3:0] din,
  input  logic [1:0] fsel,
  input  logic [3:0] alu_out,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [1:0] f,
  output logic [3:0] result,
  output logic       result_valid,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    GET_X = 2'b00,
    GET_Y = 2'b01,
    EXEC  = 2'b10,
    SHOW  = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic             btn_meta, btn_sync;
  logic             db_level, db_level_q;
  logic [CNT_W-1:0] db_cnt;
  logic             press;

  logic [3:0] x_d, y_d, result_d;
  logic [1:0] f_d;
  logic       valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // The level only moves after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level   <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt     <= '0;
    end else begin
      db_level_q <= db_level;
      if (btn_sync == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level <= btn_sync;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = db_level & ~db_level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= GET_X;
      x            <= 4'd0;
      y            <= 4'd0;
      f            <= 2'd0;
      result       <= 4'd0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      x            <= x_d;
      y            <= y_d;
      f            <= f_d;
      result       <= result_d;
      result_valid <= valid_d;
    end
  end

  // EXEC is a single settling cycle for the combinational ALU; presses there are ignored.
  always_comb begin
    state_d  = state_q;
    x_d      = x;
    y_d      = y;
    f_d      = f;
    result_d = result;
    valid_d  = result_valid;
    case (state_q)
      GET_X: begin
        if (press) begin
          x_d     = din;
          valid_d = 1'b0;
          state_d = GET_Y;
        end
      end
      GET_Y: begin
        if (press) begin
          y_d     = din;
          f_d     = fsel;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_out;
        valid_d  = 1'b1;
        state_d  = SHOW;
      end
      SHOW: begin
`ifdef ALU_SEQ_LIVE_FSEL_EN
        f_d      = fsel;
        result_d = alu_out;
`else
        f_d      = f;
`endif
        if (press) begin
          state_d = GET_X;
        end
      end
      default: state_d = GET_X;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with a 4-cycle debounce and an ALU model.
// Honours ALU_SEQ_LIVE_FSEL_EN when defined for the build.
module tb_alu_operand_sequencer;

  localparam int DB = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       btn  = 1'b0;
  logic [3:0] din  = 4'd0;
  logic [1:0] fsel = 2'd0;
  logic [3:0] alu_out;
  logic [3:0] x, y, result;
  logic [1:0] f, state;
  logic       result_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Reference ALU: add, subtract, xor, xnor.
  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] fn);
    case (fn)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  assign alu_out = alu_fn(x, y, f);

  alu_operand_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .din(din),
    .fsel(fsel),
    .alu_out(alu_out),
    .x(x),
    .y(y),
    .f(f),
    .result(result),
    .result_valid(result_valid),
    .state(state)
  );

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic [3:0] d, input logic [1:0] fs);
    @(posedge clk);
    #2;
    btn  = b;
    din  = d;
    fsel = fs;
  endtask

  task automatic pressStep(input logic [3:0] d, input logic [1:0] fs);
    applyStimulus(1'b1, d, fs);
    repeat (12) @(posedge clk);
    #2 btn = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
  endtask

  // Behavioural model: architectural registers plus a run-length view of the button.
  logic [3:0] m_x = 0, m_y = 0, m_res = 0;
  logic [1:0] m_f = 0;
  int         m_st = 0;
  bit         m_val = 0;
  bit         s1 = 0, s2 = 0, lvl = 0, lvl_prev = 0;
  bit         m_press, m_flip;
  bit         hist[$];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_x = 0; m_y = 0; m_f = 0; m_res = 0; m_val = 0; m_st = 0;
        s1 = 0; s2 = 0; lvl = 0; lvl_prev = 0;
        hist.delete();
      end else begin
        m_press = lvl && !lvl_prev;
        case (m_st)
          0: if (m_press) begin m_x = din; m_val = 0; m_st = 1; end
          1: if (m_press) begin m_y = din; m_f = fsel; m_st = 2; end
          2: begin m_res = alu_fn(m_x, m_y, m_f); m_val = 1; m_st = 3; end
          default: begin
`ifdef ALU_SEQ_LIVE_FSEL_EN
            m_res = alu_fn(m_x, m_y, m_f);
            m_f   = fsel;
`endif
            if (m_press) m_st = 0;
          end
        endcase
        hist.push_back(s2);
        if (hist.size() > DB) void'(hist.pop_front());
        m_flip = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] == lvl) m_flip = 0;
        lvl_prev = lvl;
        if (m_flip) begin
          lvl = !lvl;
          hist.delete();
        end
        s2 = s1;
        s1 = btn;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("cyc_x", x, m_x);
        checkOutput("cyc_y", y, m_y);
        checkOutput("cyc_f", {2'b00, f}, {2'b00, m_f});
        checkOutput("cyc_result", result, m_res);
        checkOutput("cyc_valid", {3'b000, result_valid}, {3'b000, m_val});
        checkOutput("cyc_state", {2'b00, state}, 4'(m_st));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [3:0] exp_res [4] = '{4'd8, 4'd2, 4'd6, 4'd9};
  logic [3:0] live_res;
  logic [1:0] live_f;

  initial begin
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_x", x, 4'd0);
    checkOutput("rst_y", y, 4'd0);
    checkOutput("rst_f", {2'b00, f}, 4'd0);
    checkOutput("rst_result", result, 4'd0);
    checkOutput("rst_valid", {3'b000, result_valid}, 4'd0);
    checkOutput("rst_state", {2'b00, state}, 4'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Add 5 + 3, with exact edge timing around the Y press.
    pressStep(4'd5, 2'b00);
    checkOutput("add_x", x, 4'd5);
    checkOutput("add_state_y", {2'b00, state}, 4'd1);
    applyStimulus(1'b1, 4'd3, 2'b00);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("add_before_press", {2'b00, state}, 4'd1);
    @(negedge clk);
    checkOutput("add_exec_state", {2'b00, state}, 4'd2);
    checkOutput("add_exec_valid", {3'b000, result_valid}, 4'd0);
    @(negedge clk);
    checkOutput("add_show_state", {2'b00, state}, 4'd3);
    checkOutput("add_result", result, 4'd8);
    checkOutput("add_valid", {3'b000, result_valid}, 4'd1);
    checkOutput("add_y", y, 4'd3);
    checkOutput("add_f", {2'b00, f}, 4'd0);
    applyStimulus(1'b0, 4'd3, 2'b00);
    repeat (12) @(posedge clk);

    // Function switches changed while showing the add result.
`ifdef ALU_SEQ_LIVE_FSEL_EN
    live_res = 4'd2;
    live_f   = 2'b01;
`else
    live_res = 4'd8;
    live_f   = 2'b00;
`endif
    applyStimulus(1'b0, 4'd3, 2'b01);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("live_result", result, live_res);
    checkOutput("live_f", {2'b00, f}, {2'b00, live_f});
    checkOutput("live_valid", {3'b000, result_valid}, 4'd1);
    applyStimulus(1'b0, 4'd3, 2'b00);
    repeat (3) @(posedge clk);

    // Sub, xor, xnor on the same operands.
    for (int i = 1; i < 4; i++) begin
      pressStep(4'd0, 2'(i));
      checkOutput("op_back_to_x", {2'b00, state}, 4'd0);
      pressStep(4'd5, 2'(i));
      pressStep(4'd3, 2'(i));
      checkOutput("op_result", result, exp_res[i]);
      checkOutput("op_state", {2'b00, state}, 4'd3);
      checkOutput("op_f", {2'b00, f}, 4'(i));
    end

    // Bouncing button: 2-cycle glitches for 40 cycles, then a steady hold.
    pressStep(4'd0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'd4, 2'b00);
      @(posedge clk);
      applyStimulus(1'b0, 4'd4, 2'b00);
      @(posedge clk);
    end
    @(negedge clk);
    checkOutput("bounce_no_press", {2'b00, state}, 4'd0);
    applyStimulus(1'b1, 4'd4, 2'b00);
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("bounce_one_press", {2'b00, state}, 4'd1);
    checkOutput("bounce_x", x, 4'd4);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("bounce_no_repeat", {2'b00, state}, 4'd1);
    applyStimulus(1'b0, 4'd4, 2'b00);
    repeat (12) @(posedge clk);

    // Reset while Y is being entered discards the partial operands.
    pressStep(4'd1, 2'b00);
    pressStep(4'd0, 2'b00);
    pressStep(4'd7, 2'b00);
    checkOutput("mid_x", x, 4'd7);
    checkOutput("mid_state", {2'b00, state}, 4'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("mid_rst_x", x, 4'd0);
    checkOutput("mid_rst_state", {2'b00, state}, 4'd0);
    checkOutput("mid_rst_result", result, 4'd0);
    checkOutput("mid_rst_valid", {3'b000, result_valid}, 4'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    pressStep(4'd9, 2'b00);
    checkOutput("after_rst_x", x, 4'd9);
    checkOutput("after_rst_state", {2'b00, state}, 4'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end sequencer for the 4-bit ALU datapath. It debounces a single step button and walks the user through entering X, then Y and the function code from board switches. It drives those registered operands into the combinational ALU, then captures the ALU output into a result register with a valid flag for the display stage. It sits directly upstream of the ALU and also holds the ALU's registered result.

## Interface
- `DEBOUNCE_CYCLES`, default 250000 — consecutive identical synchronized samples required before the debounced button level changes (10 ms at 25 MHz).
- `CNT_W`, default 18 — width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk` in 1 — sole clock; all state updates on the rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `btn` in 1 — raw, asynchronous, bouncy step button; active high.
- `din` in 4 — operand data switches.
- `fsel` in 2 — function switches: bit0 = subtract/invert (F0), bit1 = output mux select (F1).
- `alu_out` in 4 — combinational ALU result, a function of `x`, `y` and `f`.
- `x` out 4 — registered X operand to the ALU.
- `y` out 4 — registered Y operand to the ALU.
- `f` out 2 — registered function code to the ALU; f[0] = F0, f[1] = F1.
- `result` out 4 — captured ALU result.
- `result_valid` out 1 — high while `result` holds the output for the current `x`/`y`/`f`.
- `state` out 2 — current FSM state, for LEDs.

## Operation
- **Button conditioning**
  - `btn` passes through a 2-flop synchronizer.
  - The debounce counter resets to 0 whenever the synchronized sample equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES−1 with a differing sample, the debounced level flips and the counter clears.
  - `press` is a one-cycle pulse on each 0→1 transition of the debounced level. There is no pulse on release.
- **FSM states:** GET_X = 2'b00, GET_Y = 2'b01, EXEC = 2'b10, SHOW = 2'b11. The `state` output encodes these values.
  - GET_X, on `press`: x ← din, result_valid ← 0, go to GET_Y.
  - GET_Y, on `press`: y ← din, f ← fsel, go to EXEC.
  - EXEC: unconditional, lasts exactly one cycle. result ← alu_out, result_valid ← 1, go to SHOW. A `press` in EXEC is dropped.
  - SHOW, on `press`: go to GET_X. The x, y, f and result registers hold; result_valid stays 1 until the next X capture.
- Without `press`, every state holds. Operand registers change only on the listed transitions.
- **Reset values:** x = 0, y = 0, f = 0, result = 0, result_valid = 0, state = GET_X. The synchronizer flops, debounced level and counter also clear to 0.
- **Reset mid-operation:** any partially entered operands are discarded. A button held through reset release produces a `press` only after a full debounce interval.

## Timing
- `btn` edge to `press`: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 cycle, with ±1 cycle of synchronizer uncertainty.
- `press` in cycle T: the register capture and state change are visible after the edge ending T.
- y/f capture to valid result: `result` and `result_valid` update on the edge after EXEC is entered, i.e. 2 edges after the `press` cycle. `alu_out` therefore has one full cycle to settle.
- Bounces shorter than DEBOUNCE_CYCLES produce no `press`. At most one `press` per debounced press.

## Configuration
- Macro: `ALU_SEQ_LIVE_FSEL_EN`.
- **Defined:** while in SHOW, f ← fsel every cycle and result ← alu_out every cycle. `result` therefore tracks a switch change 2 cycles later, and result_valid stays 1.
- **Undefined:** f and result are frozen in SHOW. fsel is sampled only on the GET_Y press.

## Test plan
Run the bench with DEBOUNCE_CYCLES = 4 and a model of the ALU connected.

- **Reset:** assert `rst` asynchronously mid-cycle → all outputs 0 and state = GET_X immediately, with no clock edge required.
- **Add:** enter din = 5, then din = 3 with fsel = 00 → x = 5, y = 3, f = 00, result = 8, result_valid = 1, state = 3. Check the result update occurs 2 edges after the second `press`.
- **Sub and XOR:** repeat with fsel = 01 → result = 2. With fsel = 10 → result = 6. With fsel = 11 → result = 9.
- **Bounce:** toggle `btn` with 2-cycle glitches for 40 cycles, then hold high → exactly one `press` and one state advance.
- **Live select:** in SHOW, change fsel 00 → 01 → with the macro defined, result goes 8 → 2 within 2 cycles. With it undefined, result stays 8.
- **Reset mid-entry:** reset asserted in GET_Y after x = 7 → x = 0, state = GET_X. The next `press` captures din into x.
